// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion controller.
//   sar_state_t      : controller state encoding
//   SarNBitsDefault  : default result width
//   PhaseCntW        : width of the sample/settle phase counter (covers 1..15 cycles)
package sar_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StSettle,
    StCompare,
    StDone
  } sar_state_t;

  localparam int unsigned SarNBitsDefault = 8;
  localparam int unsigned PhaseCntW       = 4;

endpackage

// File: rtl/sar_avg_acc.sv
// Conversion averager: accumulates 2^AVG_LOG2 results and reports their truncated mean.
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset, clears accumulator and count
//   conv_valid_i  one-cycle strobe when a conversion result is final
//   conv_data_i   that conversion result
//   last_o        the strobed conversion is the last one of the group
//   avg_o         mean of the group including the current conversion (valid with last_o)
module sar_avg_acc #(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              conv_valid_i,
  input  logic [N_BITS-1:0] conv_data_i,
  output logic              last_o,
  output logic [N_BITS-1:0] avg_o
);

  localparam int unsigned AccW = N_BITS + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [AccW-1:0] acc_q, sum;
  logic [CntW-1:0] cnt_q;

  assign sum    = acc_q + AccW'(conv_data_i);
  assign last_o = (AVG_LOG2 == 0) ? 1'b1 : (cnt_q == '1);
  assign avg_o  = N_BITS'(sum >> AVG_LOG2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (conv_valid_i) begin
      if (last_o) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_conv_ctrl.sv
// Sequencing controller for an N_BITS SAR ADC: sample, then one settle/compare pair per bit,
// MSB first, then a done pulse with the result on dout.
// Optional feature macro: SAR_AVG_EN -- average 2^AVG_LOG2 conversions per done pulse.
// Ports:
//   clk       clock, all state on rising edge
//   rst       synchronous active-high reset
//   en        continuous mode: restart after each done while high
//   start     single-shot request, honoured only when idle
//   cmp       comparator result (1 = vin >= dac_code), used only while cmp_en is high
//   smpl      sample switch enable
//   cmp_en    comparator latch strobe
//   dac_code  capacitive-DAC trial code
//   busy      high whenever not idle
//   done      one-cycle pulse when dout updates
//   dout      last completed result
module sar_conv_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS        = SarNBitsDefault,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1
`ifdef SAR_AVG_EN
  ,
  parameter int unsigned AVG_LOG2      = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              cmp,
  output logic              smpl,
  output logic              cmp_en,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] dout
);

  localparam int unsigned BitW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [PhaseCntW-1:0] SampleLoad = PhaseCntW'(SAMPLE_CYCLES - 1);
  localparam logic [PhaseCntW-1:0] SettleLoad =
      (SETTLE_CYCLES == 0) ? '0 : PhaseCntW'(SETTLE_CYCLES - 1);
  localparam logic [BitW-1:0] MsbIdx = BitW'(N_BITS - 1);
  // With no settling time each bit trial goes straight to the compare.
  localparam sar_state_t TrialSt = (SETTLE_CYCLES == 0) ? StCompare : StSettle;

  sar_state_t          state_q, state_d;
  logic [PhaseCntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0]     idx_q, idx_d;
  logic [N_BITS-1:0]   res_q, res_d, res_upd, trial;
  logic [N_BITS-1:0]   dout_q, dout_d, conv_word;
  logic                conv_end, conv_last, fin_q;

  assign trial    = res_q | (N_BITS'(1) << idx_q);
  assign conv_end = (state_q == StCompare) && (idx_q == '0);

  // Result with the bit under test replaced by the comparator decision.
  always_comb begin
    res_upd        = res_q;
    res_upd[idx_q] = cmp;
  end

`ifdef SAR_AVG_EN
  sar_avg_acc #(
    .N_BITS  (N_BITS),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk_i       (clk),
    .rst_i       (rst),
    .conv_valid_i(conv_end),
    .conv_data_i (res_upd),
    .last_o      (conv_last),
    .avg_o       (conv_word)
  );

  // Remembers whether the DONE being entered closes an averaging group.
  always_ff @(posedge clk) begin
    if (rst) begin
      fin_q <= 1'b0;
    end else if (conv_end) begin
      fin_q <= conv_last;
    end
  end
`else
  assign conv_last = 1'b1;
  assign conv_word = res_upd;
  assign fin_q     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    res_d    = res_q;
    dout_d   = dout_q;
    smpl     = 1'b0;
    cmp_en   = 1'b0;
    dac_code = '0;
    done     = 1'b0;
    busy     = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (start || en) begin
          state_d = StSample;
          cnt_d   = SampleLoad;
          res_d   = '0;
        end
      end
      StSample: begin
        smpl = 1'b1;
        if (cnt_q == '0) begin
          state_d = TrialSt;
          cnt_d   = SettleLoad;
          idx_d   = MsbIdx;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        dac_code = trial;
        if (cnt_q == '0) begin
          state_d = StCompare;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCompare: begin
        dac_code = trial;
        cmp_en   = 1'b1;
        res_d    = res_upd;
        if (idx_q == '0) begin
          state_d = StDone;
          if (conv_last) begin
            dout_d = conv_word;
          end
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = TrialSt;
          cnt_d   = SettleLoad;
        end
      end
      StDone: begin
        done = fin_q;
        // Mid-group conversions restart unconditionally; en only matters at group end.
        if (!fin_q || en) begin
          state_d = StSample;
          cnt_d   = SampleLoad;
          res_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: doc/sar_conv_ctrl.md
Name: sar_conv_ctrl

Overview:
- Sequencing controller for the 8-bit SAR ADC core: drives sample switch, capacitive-DAC trial code and comparator strobe; assembles result bits MSB-first.
- Sits between top-level pin logic (enable/start from ui_in, result to uo_out, done to uio_out[0]) and the analog SAR array/comparator.
- Supports single-shot (start pulse) and continuous (en held high) conversion.

Parameters:
- N_BITS, 8, result width / number of bit trials.
- SAMPLE_CYCLES, 2, cycles smpl held high (legal 1..15).
- SETTLE_CYCLES, 1, DAC settling cycles before each compare (legal 0..15).
- AVG_LOG2, 2, log2 of conversions averaged; used only with SAR_AVG_EN.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  continuous mode: start a new conversion after each DONE while high.
- start  input  1  single-shot request, sampled in IDLE only.
- cmp  input  1  comparator result, valid in COMPARE; 1 = vin >= DAC trial (keep bit).
- smpl  output  1  sample switch enable.
- cmp_en  output  1  comparator latch strobe.
- dac_code  output  N_BITS  DAC trial code.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when dout updates.
- dout  output  N_BITS  last completed result, held until next done.

Behaviour:
- Reset (rst=1 at edge): state IDLE; smpl=0, cmp_en=0, busy=0, done=0, dac_code=0, dout=0, internal result/counters cleared. Applies mid-conversion too; the partial result is discarded.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DONE (enum in package).
- IDLE: start|en at edge -> SAMPLE; phase counter loaded; result cleared.
- SAMPLE: smpl=1, dac_code=0; stays SAMPLE_CYCLES cycles -> SETTLE with bit index i=N_BITS-1 (-> COMPARE directly if SETTLE_CYCLES=0).
- SETTLE: dac_code = result | (1<<i); stays SETTLE_CYCLES cycles -> COMPARE.
- COMPARE: same dac_code, cmp_en=1 for exactly one cycle; at its ending edge result[i] <= cmp. If i>0: i-- -> SETTLE/COMPARE. If i==0 -> DONE.
- DONE: done=1 for one cycle, dout <= final result on the edge entering DONE (visible with done), dac_code=0. Next: en ? SAMPLE : IDLE.
- Latency: start accepted at edge k -> done high in cycle k + SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+1) + 1 (defaults: k+19). Continuous period = that count (19 cycles).
- start while busy: ignored, no queuing. start and en both high: one conversion, en then governs continuation.
- en deasserted mid-conversion: current conversion completes, done pulses, then IDLE.
- cmp ignored outside COMPARE. dac_code never exceeds 2^N_BITS-1.

Optional Feature:
- Macro SAR_AVG_EN.
- Defined: 2^AVG_LOG2 back-to-back conversions accumulated in an (N_BITS+AVG_LOG2)-bit accumulator; dout = acc >> AVG_LOG2 (truncation); done pulses only after the last conversion; intermediate DONE states have done=0 and proceed to SAMPLE regardless of en. Reset or rst clears the accumulator and count.
- Undefined: every conversion updates dout and pulses done; AVG_LOG2 unused.

Decomposition:
- Package sar_pkg: state enum sar_state_t (IDLE, SAMPLE, SETTLE, COMPARE, DONE), default N_BITS, phase-counter width constant.
- Sub-module sar_avg_acc (accumulate/count/shift), instantiated only under SAR_AVG_EN; the FSM stays in sar_conv_ctrl.

Test Plan:
- Single shot, ideal comparator model cmp=(0xA5>=dac_code), start pulse at edge k -> dac_code sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done at k+19, dout=0xA5, back to IDLE, busy=0.
- Edge codes: vin 0x00 -> dout 0x00; vin 0xFF -> dout 0xFF; no dac_code overflow.
- Continuous: en=1, vin 0x3C then 0xC3 -> done pulses every 19 cycles, dout 0x3C then 0xC3; en dropped mid-2nd conversion -> that conversion completes, then IDLE.
- Reset mid-conversion at bit 4 -> next cycle all outputs 0, state IDLE; start ignored while busy (no extra done).
- SETTLE_CYCLES=0, SAMPLE_CYCLES=1 -> done at k+10, correct result.
- SAR_AVG_EN, AVG_LOG2=2, vin codes 0x10,0x11,0x12,0x13 -> single done after 4 conversions (k+76), dout=0x11.
